// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and a program memory loaded while idle,
// and presents one instruction per cycle with stall, redirect-squash and halt handling.
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        INSTR_W  = 16,
  parameter logic [INSTR_W-1:0] NOP_WORD = 16'hE800,
  parameter logic [4:0]         HALT_OP  = 5'b11111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               run,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  fetch_pc,
  output logic               halted
);

  localparam int unsigned       DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PC = '1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST, S_HALT} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic                 halted_q, halted_d;
  logic                 mem_we_c;
  logic                 halt_word_c;
  logic [INSTR_W-1:0]   mem_q [DEPTH];

  assign halt_word_c = instr_valid_q && (instr_q[INSTR_W-1 -: 5] == HALT_OP);

  // Next-state and next-output logic; redirect outranks stall, stall outranks halt.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_pc_d    = fetch_pc_q;
    halted_d      = halted_q;
    mem_we_c      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        mem_we_c = prog_we;
        if (run) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH, S_LAST: begin
        if (redirect_valid) begin
          state_d       = S_FETCH;
          pc_d          = redirect_pc;
          instr_d       = NOP_WORD;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          if (halt_word_c || (state_q == S_LAST)) begin
            state_d       = S_HALT;
            instr_d       = NOP_WORD;
            instr_valid_d = 1'b0;
            halted_d      = 1'b1;
          end else begin
            instr_d       = mem_q[pc_q];
            instr_valid_d = 1'b1;
            fetch_pc_d    = pc_q;
            // Sequential fetch stops at the top of memory instead of wrapping.
            if (pc_q == LAST_PC) state_d = S_LAST;
            else                 pc_d    = pc_q + ADDR_W'(1);
          end
        end
      end
      S_HALT: begin
        instr_d       = NOP_WORD;
        instr_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      halted_q      <= halted_d;
    end
  end

  // Program memory is never cleared so a reset and rerun replays the same program.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) mem_q[prog_addr] <= prog_data;
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a cycle-level behavioural model compared
// every cycle, plus literal expectations taken from hand-worked sequences.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic        run;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic [7:0]  fetch_pc;
  logic        halted;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .run            (run),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .fetch_pc       (fetch_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a "next address" counter that may run one past the end of memory.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode;
  int          m_next;
  logic [15:0] m_mem [256];
  logic [15:0] e_instr;
  logic        e_valid;
  logic [7:0]  e_pc;
  logic        e_halt;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_IDLE; m_next = 0;
      e_instr = 16'hE800; e_valid = 1'b0; e_pc = 8'h00; e_halt = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (prog_we) m_mem[prog_addr] = prog_data;
      if (run) begin m_mode = M_RUN; m_next = 0; end
    end else if (m_mode == M_RUN) begin
      if (redirect_valid) begin
        m_next = int'(redirect_pc); e_instr = 16'hE800; e_valid = 1'b0;
      end else if (!stall) begin
        if ((e_valid && e_instr[15:11] == 5'b11111) || m_next > 255) begin
          m_mode = M_HALT; e_instr = 16'hE800; e_valid = 1'b0; e_halt = 1'b1;
        end else begin
          e_instr = m_mem[m_next]; e_valid = 1'b1; e_pc = m_next[7:0];
          m_next = m_next + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_instr", {16'h0, instr}, {16'h0, e_instr});
      chk("model_valid", {31'h0, instr_valid}, {31'h0, e_valid});
      chk("model_fetch_pc", {24'h0, fetch_pc}, {24'h0, e_pc});
      chk("model_halted", {31'h0, halted}, {31'h0, halted});
      chk("model_halted_exp", {31'h0, halted}, {31'h0, e_halt});
    end
  end

  task automatic lit(input string name, input logic [15:0] ei, input logic ev,
                     input logic [7:0] ep, input logic eh);
    chk({name, "_instr"}, {16'h0, instr}, {16'h0, ei});
    chk({name, "_valid"}, {31'h0, instr_valid}, {31'h0, ev});
    chk({name, "_pc"}, {24'h0, fetch_pc}, {24'h0, ep});
    chk({name, "_halted"}, {31'h0, halted}, {31'h0, eh});
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = 8'h00; prog_data = 16'h0000;
    run = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    step(); step();
    cmp_en = 1'b1;
    lit("reset", 16'hE800, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;

    // Filler program with no halt opcode, then the test program at 0..3.
    for (int i = 0; i < 256; i++) begin
      prog_we = 1'b1; prog_addr = 8'(i); prog_data = 16'h1000 | 16'(i);
      step();
    end
    prog_addr = 8'h00; prog_data = 16'h0123; step();
    prog_addr = 8'h01; prog_data = 16'h8456; step();
    prog_addr = 8'h02; prog_data = 16'hC0A1; step();
    lit("idle_hold", 16'hE800, 1'b0, 8'h00, 1'b0);
    prog_addr = 8'h03; prog_data = 16'hF800; run = 1'b1; step();
    prog_we = 1'b0; run = 1'b0;

    // Straight-line run to the halt word.
    step(); lit("seq0", 16'h0123, 1'b1, 8'h00, 1'b0);
    step(); lit("seq1", 16'h8456, 1'b1, 8'h01, 1'b0);
    step(); lit("seq2", 16'hC0A1, 1'b1, 8'h02, 1'b0);
    step(); lit("seq3", 16'hF800, 1'b1, 8'h03, 1'b0);
    step(); lit("halt", 16'hE800, 1'b0, 8'h03, 1'b1);
    // Everything is ignored while halted, including memory writes.
    prog_we = 1'b1; prog_addr = 8'h02; prog_data = 16'hFFFF; run = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    step(); step();
    lit("halt_sticky", 16'hE800, 1'b0, 8'h03, 1'b1);
    prog_we = 1'b0; run = 1'b0; redirect_valid = 1'b0;

    // Stall while presenting 8456.
    do_reset();
    lit("reset2", 16'hE800, 1'b0, 8'h00, 1'b0);
    run = 1'b1; step(); run = 1'b0;
    step(); step(); lit("pre_stall", 16'h8456, 1'b1, 8'h01, 1'b0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); lit("stall", 16'h8456, 1'b1, 8'h01, 1'b0);
    end
    stall = 1'b0;
    step(); lit("post_stall", 16'hC0A1, 1'b1, 8'h02, 1'b0);

    // Redirect to 0x10.
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    step(); lit("redir_bubble", 16'hE800, 1'b0, 8'h02, 1'b0);
    redirect_valid = 1'b0;
    step(); lit("redir_t0", 16'h1010, 1'b1, 8'h10, 1'b0);
    step(); lit("redir_t1", 16'h1011, 1'b1, 8'h11, 1'b0);

    // Halt word squashed by a redirect that coincides with stall.
    redirect_valid = 1'b1; redirect_pc = 8'h03;
    step(); redirect_valid = 1'b0;
    step(); lit("halt_word", 16'hF800, 1'b1, 8'h03, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 8'h00; stall = 1'b1;
    step(); lit("squash", 16'hE800, 1'b0, 8'h03, 1'b0);
    redirect_valid = 1'b0; stall = 1'b0;
    step(); lit("refetch0", 16'h0123, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) step();
    lit("halt_again", 16'hE800, 1'b0, 8'h03, 1'b1);

    // End of memory: no wrap, halts after 0xFF.
    do_reset();
    run = 1'b1; step(); run = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    step(); redirect_valid = 1'b0;
    step(); lit("top_fe", 16'h10FE, 1'b1, 8'hFE, 1'b0);
    step(); lit("top_ff", 16'h10FF, 1'b1, 8'hFF, 1'b0);
    step(); lit("top_halt", 16'hE800, 1'b0, 8'hFF, 1'b1);
    step(); lit("top_halt2", 16'hE800, 1'b0, 8'hFF, 1'b1);

    // Reset mid-fetch; writes during FETCH must not land.
    do_reset();
    run = 1'b1; step(); run = 1'b0;
    prog_we = 1'b1; prog_addr = 8'h00; prog_data = 16'hABCD;
    step();
    redirect_valid = 1'b1; redirect_pc = 8'h04;
    step(); redirect_valid = 1'b0;
    step(); step(); lit("at5", 16'h1005, 1'b1, 8'h05, 1'b0);
    prog_we = 1'b0;
    do_reset();
    lit("midreset", 16'hE800, 1'b0, 8'h00, 1'b0);
    run = 1'b1; step(); run = 1'b0;
    step(); lit("rerun0", 16'h0123, 1'b1, 8'h00, 1'b0);
    step(); step(); step(); step();
    lit("rerun_halt", 16'hE800, 1'b0, 8'h03, 1'b1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
